// File: rtl/traffic_phase_controller.sv
// Actuated four-approach intersection controller: latched vehicle calls, protected
// left phases, yellow/all-red clearance, rest-in-green and a night flash mode.
module traffic_phase_controller #(
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 10,
  parameter int LEFT_TIME    = 3,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 1,
  parameter int TW           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_north,
  input  logic       car_south,
  input  logic       car_east,
  input  logic       car_west,
  input  logic       car_north_left,
  input  logic       car_south_left,
  input  logic       car_east_left,
  input  logic       car_west_left,
  input  logic       flash_mode,
  output logic [1:0] light_north,
  output logic [1:0] light_south,
  output logic [1:0] light_east,
  output logic [1:0] light_west,
  output logic [1:0] left_north,
  output logic [1:0] left_south,
  output logic [1:0] left_east,
  output logic [1:0] left_west,
  output logic [2:0] phase_id
);

  // state    | meaning
  // S_GREEN  | phase in phase_q is being served
  // S_YELLOW | clearance of the ending phase's green heads
  // S_ALL_RED| all heads red; next phase chosen when the timer expires
  // S_FLASH  | night flash: NS through flashing yellow, all else red
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALL_RED, S_FLASH} state_t;

  localparam logic [1:0] H_GREEN  = 2'b00;
  localparam logic [1:0] H_YELLOW = 2'b01;
  localparam logic [1:0] H_RED    = 2'b10;
  localparam logic [1:0] H_FLASH  = 2'b11;

  localparam logic [TW-1:0] T_MAX_GREEN = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] T_MIN_MARK  = TW'(MAX_GREEN - MIN_GREEN);
  localparam logic [TW-1:0] T_LEFT      = TW'(LEFT_TIME - 1);
  localparam logic [TW-1:0] T_YELLOW    = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] T_ALL_RED   = TW'(ALL_RED_TIME - 1);

  state_t          state_q, state_d;
  logic [2:0]      phase_q, phase_d;
  logic [TW-1:0]   timer_q, timer_d, timer_dec;
  logic            force_ns_q, force_ns_d;
  logic [7:0]      call_q, call_d;
  logic [7:0]      detect, green_mask;

  logic [3:0][1:0] light_g, left_g;
  logic [3:0][1:0] light_o, left_o;
  logic [1:0]      idx_a, idx_b;

  logic            is_thru, min_done, conflict;
  logic            sel_ew, sel_la, sel_lb;
  logic [1:0]      sel_code;
  logic [2:0]      sel_phase;

  // call bits: [3:0] through N,S,E,W; [7:4] left N,S,E,W
  assign detect = {car_west_left, car_east_left, car_south_left, car_north_left,
                   car_west, car_east, car_south, car_north};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      green_mask[i]   = (light_o[i] == H_GREEN);
      green_mask[i+4] = (left_o[i] == H_GREEN);
    end
  end

  assign call_d = (call_q | detect) & ~green_mask;

  assign is_thru   = (phase_q[1:0] == 2'd0);
  assign timer_dec = (timer_q == '0) ? '0 : timer_q - 1'b1;
  assign min_done  = (timer_q <= T_MIN_MARK);
  assign conflict  = phase_q[2] ? |{call_q[5:4], call_q[1:0]}
                                : |{call_q[7:6], call_q[3:2]};

  // Alternate axis after a through phase; a left phase always hands over to its own through.
  always_comb begin
    sel_ew   = force_ns_q ? 1'b0 : (is_thru ? ~phase_q[2] : phase_q[2]);
    sel_la   = sel_ew ? call_q[6] : call_q[4];
    sel_lb   = sel_ew ? call_q[7] : call_q[5];
    sel_code = 2'd0;
    if (force_ns_q || is_thru) begin
      if (sel_la && sel_lb)  sel_code = 2'd3;
      else if (sel_la)       sel_code = 2'd1;
      else if (sel_lb)       sel_code = 2'd2;
    end
    sel_phase = {sel_ew, sel_code};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_ALL_RED;
      phase_q    <= 3'd0;
      timer_q    <= T_ALL_RED;
      force_ns_q <= 1'b1;
      call_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      timer_q    <= timer_d;
      force_ns_q <= force_ns_d;
      call_q     <= call_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    timer_d    = timer_dec;
    force_ns_d = force_ns_q;
    case (state_q)
      S_GREEN: begin
        if (is_thru ? (min_done && conflict) : (timer_q == '0)) begin
          state_d = S_YELLOW;
          timer_d = T_YELLOW;
        end
      end
      S_YELLOW: begin
        if (timer_q == '0) begin
          state_d = S_ALL_RED;
          timer_d = T_ALL_RED;
        end
      end
      S_ALL_RED: begin
        if (timer_q == '0) begin
          if (flash_mode) begin
            state_d    = S_FLASH;
            phase_d    = 3'd0;
            force_ns_d = 1'b1;
          end else begin
            state_d    = S_GREEN;
            phase_d    = sel_phase;
            force_ns_d = 1'b0;
            timer_d    = (sel_phase[1:0] == 2'd0) ? T_MAX_GREEN : T_LEFT;
          end
        end
      end
      S_FLASH: begin
        if (!flash_mode) begin
          state_d    = S_ALL_RED;
          timer_d    = T_ALL_RED;
          force_ns_d = 1'b1;
        end
      end
      default: begin
        state_d = S_ALL_RED;
        timer_d = T_ALL_RED;
      end
    endcase
  end

  // Head pattern of the current phase while green; index 0..3 = N,S,E,W.
  assign idx_a = {phase_q[2], 1'b0};
  assign idx_b = {phase_q[2], 1'b1};

  always_comb begin
    light_g = {4{H_RED}};
    left_g  = {4{H_RED}};
    case (phase_q[1:0])
      2'd0: begin
        light_g[idx_a] = H_GREEN;
        light_g[idx_b] = H_GREEN;
        left_g[idx_a]  = H_FLASH;
        left_g[idx_b]  = H_FLASH;
      end
      2'd1: begin
        light_g[idx_a] = H_GREEN;
        left_g[idx_a]  = H_GREEN;
      end
      2'd2: begin
        light_g[idx_b] = H_GREEN;
        left_g[idx_b]  = H_GREEN;
      end
      default: begin
        left_g[idx_a]  = H_GREEN;
        left_g[idx_b]  = H_GREEN;
      end
    endcase
  end

  always_comb begin
    light_o = {4{H_RED}};
    left_o  = {4{H_RED}};
    case (state_q)
      S_GREEN: begin
        light_o = light_g;
        left_o  = left_g;
      end
      S_YELLOW: begin
        for (int i = 0; i < 4; i++) begin
          light_o[i] = (light_g[i] == H_GREEN) ? H_YELLOW : H_RED;
          left_o[i]  = (left_g[i] == H_GREEN) ? H_YELLOW : H_RED;
        end
      end
      S_FLASH: begin
        light_o[0] = H_FLASH;
        light_o[1] = H_FLASH;
      end
      default: ;
    endcase
  end

  assign light_north = light_o[0];
  assign light_south = light_o[1];
  assign light_east  = light_o[2];
  assign light_west  = light_o[3];
  assign left_north  = left_o[0];
  assign left_south  = left_o[1];
  assign left_east   = left_o[2];
  assign left_west   = left_o[3];
  assign phase_id    = phase_q;

endmodule
